// File: rtl/nf_tick_pkg.sv
// Shared constants for the tick scheduler: register map, channel states and
// CH_CFG field positions.
package nf_tick_pkg;

    localparam logic [4:0] ADDR_CTRL    = 5'd0;
    localparam logic [4:0] ADDR_PRESC   = 5'd1;
    localparam logic [4:0] ADDR_STATUS  = 5'd2;
    localparam logic [4:0] ADDR_CH_BASE = 5'd4;

    localparam int CFG_EN_BIT   = 0;
    localparam int CFG_MODE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

    // Each channel owns a CFG/PER word pair starting at ADDR_CH_BASE.
    function automatic logic [4:0] ch_cfg_addr(input int ch);
        return ADDR_CH_BASE + 5'(2 * ch);
    endfunction

    function automatic logic [4:0] ch_per_addr(input int ch);
        return ADDR_CH_BASE + 5'(2 * ch + 1);
    endfunction

endpackage

// File: rtl/nf_tick_chan.sv
// One scheduler channel: CFG/PER registers, down-counter, IDLE/RUN/DONE FSM
// and the registered tick strobe.
module nf_tick_chan
    import nf_tick_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             base_i,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_wd_i,
    input  logic             per_we_i,
    input  logic [CNT_W-1:0] per_wd_i,
    output logic             en_o,
    output logic             mode_o,
    output logic [CNT_W-1:0] per_o,
    output logic             run_o,
    output logic             done_set_o,
    output logic             tick_o
);

    chan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_q;
    logic             en_q;
    logic             mode_q;
    logic             tick_q;
    logic             expire;

    // A CH_CFG write in the expiry cycle suppresses the tick and the done set.
    assign expire     = (state_q == ST_RUN) && base_i && (cnt_q == '0) && !cfg_we_i;
    assign done_set_o = expire && mode_q;

    assign en_o   = en_q;
    assign mode_o = mode_q;
    assign per_o  = per_q;
    assign run_o  = (state_q == ST_RUN);
    assign tick_o = tick_q;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            en_q    <= 1'b0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (per_we_i) begin
                per_q <= per_wd_i;
            end
            if (cfg_we_i) begin
                en_q   <= cfg_wd_i[CFG_EN_BIT];
                mode_q <= cfg_wd_i[CFG_MODE_BIT];
                if (cfg_wd_i[CFG_EN_BIT]) begin
                    state_q <= ST_RUN;
                    cnt_q   <= per_q;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else if (expire) begin
                tick_q <= 1'b1;
                if (mode_q) begin
                    state_q <= ST_DONE;
                    en_q    <= 1'b0;
                end else begin
                    cnt_q <= per_q;
                end
            end else if ((state_q == ST_RUN) && base_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_tick_ctrl.sv
// Multi-channel tick scheduler: shared prescaler, register decode and
// CH_NUM channel instances.
module nf_tick_ctrl
    import nf_tick_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int PRE_W  = 26,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        addr,
    input  logic [31:0]       wd,
    input  logic              we,
    output logic [31:0]       rd,
    output logic [CH_NUM-1:0] tick,
    output logic              busy
);

    logic              gen_q, gen_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [PRE_W-1:0]  pcnt_q, pcnt_d;
    logic [PRE_W-1:0]  pcmp_q, pcmp_d;
    logic [CH_NUM-1:0] done_q, done_d;
    logic              base;
    logic [CH_NUM-1:0] cfg_we, per_we, en, mode, run, done_set;
    logic [CNT_W-1:0]  per [CH_NUM];
    logic              wd_unused;

    assign wd_unused = ^wd;
    assign base      = gen_q && (pcnt_q == pcmp_q);
    assign busy      = |run;

    // NOTE: every always_comb output gets a default first so no latch can form.
    always_comb begin
        gen_d   = gen_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        pcmp_d  = pcmp_q;
        done_d  = done_q | done_set;
        if (we && (addr == ADDR_CTRL))   gen_d   = wd[0];
        if (we && (addr == ADDR_PRESC))  presc_d = wd[PRE_W-1:0];
        // A done set beats a same-cycle W1C of the same bit.
        if (we && (addr == ADDR_STATUS)) done_d  = (done_q & ~wd[CH_NUM-1:0]) | done_set;
        if (!gen_q) begin
            pcnt_d = '0;
        end else if (base) begin
            pcnt_d = '0;
            pcmp_d = presc_q;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_q   <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            pcmp_q  <= '0;
            done_q  <= '0;
        end else begin
            gen_q   <= gen_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            pcmp_q  <= pcmp_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        assign cfg_we[i] = we && (addr == ch_cfg_addr(i));
        assign per_we[i] = we && (addr == ch_per_addr(i));

        nf_tick_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .reset      (reset),
            .base_i     (base),
            .cfg_we_i   (cfg_we[i]),
            .cfg_wd_i   (wd[1:0]),
            .per_we_i   (per_we[i]),
            .per_wd_i   (wd[CNT_W-1:0]),
            .en_o       (en[i]),
            .mode_o     (mode[i]),
            .per_o      (per[i]),
            .run_o      (run[i]),
            .done_set_o (done_set[i]),
            .tick_o     (tick[i])
        );
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_CTRL:   rd[0]            = gen_q;
            ADDR_PRESC:  rd[PRE_W-1:0]    = presc_q;
            ADDR_STATUS: rd[CH_NUM-1:0]   = done_q;
            default:     ;
        endcase
        for (int i = 0; i < CH_NUM; i++) begin
            if (addr == ch_cfg_addr(i)) begin
                rd[CFG_EN_BIT]   = en[i];
                rd[CFG_MODE_BIT] = mode[i];
            end
            if (addr == ch_per_addr(i)) rd[CNT_W-1:0] = per[i];
        end
    end

endmodule
